vga_pixel_streamer: RTL and testbench

//  Consumer stage after the SDRAM read master. Pops 32-bit words from the pixel FIFO, each holding two
//  RGB565 pixels, and drives 640x480@60 VGA timing, syncs and 8-bit RGB from one system clock.

---
 rtl/vga_pixel_streamer_if.sv | 11 +
 rtl/vga_pixel_streamer.sv | 131 +++++++++++++
 tb/tb_vga_pixel_streamer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_streamer_if.sv
// Read port of the show-ahead pixel FIFO feeding the VGA streamer.
// fifo_rd_data is the head word whenever fifo_empty is low; fifo_rd_en pops it.
interface vga_pixel_streamer_if;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_rd_en;

  // master = the streamer (pops words), slave = the FIFO (supplies them)
  modport master (input fifo_rd_data, input fifo_empty, output fifo_rd_en);
  modport slave  (output fifo_rd_data, output fifo_empty, input fifo_rd_en);
endinterface

// File: rtl/vga_pixel_streamer.sv
// VGA timing generator and pixel streamer: pops RGB565 pixel pairs from a show-ahead FIFO
// and drives registered syncs, blank and RGB888 on each pixel tick of a single system clock.
module vga_pixel_streamer #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic                        clk,
  input  logic                        reset,
  vga_pixel_streamer_if.master        fifo,
  output logic                        frame_start,
  output logic [7:0]                  vga_r,
  output logic [7:0]                  vga_g,
  output logic [7:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        vga_blank_n,
  output logic                        underflow
);

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int HW           = $clog2(H_TOTAL);
  localparam int VW           = $clog2(V_TOTAL);
  localparam int DW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          pix_tick;
  logic          h_last;
  logic          v_last;
  logic          visible;
  logic          hsync_on;
  logic          vsync_on;
  logic          fetch;
  logic [15:0]   pix_hi;
  logic          word_ok;
  logic [15:0]   pix_next;
  logic [23:0]   rgb_next;

  // Bit replication keeps full-scale 565 values at full-scale 888 (0x1F -> 0xFF).
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  assign pix_tick = (div_cnt == DW'(CLK_DIV - 1));
  assign h_last   = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last   = (v_cnt == VW'(V_TOTAL - 1));
  assign visible  = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
  assign hsync_on = (h_cnt >= HW'(H_SYNC_START)) && (h_cnt < HW'(H_SYNC_END));
  assign vsync_on = (v_cnt >= VW'(V_SYNC_START)) && (v_cnt < VW'(V_SYNC_END));
  assign fetch    = pix_tick && visible && !h_cnt[0];

  // The pop strobe is combinational so the FIFO advances on the same edge the head word is latched.
  assign fifo.fifo_rd_en = !reset && fetch && !fifo.fifo_empty;
  assign frame_start     = !reset && pix_tick && h_last && v_last;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    pix_next = '0;
    if (visible) begin
      if (!h_cnt[0]) begin
        if (!fifo.fifo_empty) begin
          pix_next = fifo.fifo_rd_data[15:0];
        end
      end else if (word_ok) begin
        pix_next = pix_hi;
      end
    end
  end

  assign rgb_next = rgb565_to_rgb888(pix_next);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_hi      <= '0;
      word_ok     <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
      if (pix_tick) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end

        {vga_r, vga_g, vga_b} <= rgb_next;
        vga_hs                <= !hsync_on;
        vga_vs                <= !vsync_on;
        vga_blank_n           <= visible;

        // A missed word is not made up later; the odd pixel of that pair goes black too.
        if (fetch) begin
          if (fifo.fifo_empty) begin
            word_ok   <= 1'b0;
            underflow <= 1'b1;
          end else begin
            word_ok <= 1'b1;
            pix_hi  <= fifo.fifo_rd_data[31:16];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Self-checking bench for vga_pixel_streamer on a shrunken raster, compared every clock
// against a position-arithmetic model, with literal pins on colours, sync timing and pop counts.
module tb_vga_pixel_streamer;

  localparam int CLK_DIV     = 2;
  localparam int H_VISIBLE   = 8;
  localparam int H_FP        = 2;
  localparam int H_SYNC      = 3;
  localparam int H_BP        = 2;
  localparam int V_VISIBLE   = 4;
  localparam int V_FP        = 1;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 1;
  localparam int H_TOTAL     = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL     = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;
  localparam int HS_START    = H_VISIBLE + H_FP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, underflow;

  vga_pixel_streamer_if fi ();

  vga_pixel_streamer #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo        (fi),
    .frame_start (frame_start),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // FIFO contents and stimulus knobs
  logic [31:0] q[$];
  bit          forced_empty;
  int          push_rate;
  int          empty_rate;

  // Model state: expected registered outputs plus the position of the upcoming edge
  logic [23:0] e_rgb;
  logic        e_hs, e_vs, e_blank, e_uf;
  logic [31:0] m_word;
  bit          m_ok;
  bit          m_tick, m_vis;
  int          m_h, m_v;
  int          n_edges;
  bit          armed;

  int n_checks, n_pass, pops, frames;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] expand565(input logic [15:0] p);
    int r5, g6, b5;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  task automatic drive_inputs();
    fi.fifo_empty   = forced_empty || (q.size() == 0);
    fi.fifo_rd_data = (q.size() > 0) ? q[0] : $urandom;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge,
  // then change inputs 1 time unit later.
  task automatic step();
    bit dut_pop;
    int n, p;
    @(negedge clk);
    m_tick = 1'b0;
    m_h    = 0;
    m_v    = 0;
    if (!reset) begin
      n = n_edges + 1;
      if (n % CLK_DIV == 0) begin
        m_tick = 1'b1;
        p      = (n / CLK_DIV - 1) % FRAME_TICKS;
        m_h    = p % H_TOTAL;
        m_v    = p / H_TOTAL;
      end
    end
    m_vis = m_tick && (m_h < H_VISIBLE) && (m_v < V_VISIBLE);
    if (armed) begin
      check("rd_en", fi.fifo_rd_en, m_vis && (m_h % 2 == 0) && !fi.fifo_empty);
      check("frame_start", frame_start, m_tick && (m_h == H_TOTAL - 1) && (m_v == V_TOTAL - 1));
      check("rgb", {vga_r, vga_g, vga_b}, e_rgb);
      check("hs", vga_hs, e_hs);
      check("vs", vga_vs, e_vs);
      check("blank_n", vga_blank_n, e_blank);
      check("underflow", underflow, e_uf);
    end
    dut_pop = (fi.fifo_rd_en === 1'b1);
    if (dut_pop) pops++;
    if (frame_start === 1'b1) frames++;

    @(posedge clk);
    if (reset) begin
      e_rgb   = '0;
      e_hs    = 1'b1;
      e_vs    = 1'b1;
      e_blank = 1'b0;
      e_uf    = 1'b0;
      m_ok    = 1'b0;
      n_edges = 0;
      armed   = 1'b1;
    end else begin
      n_edges++;
      if (m_tick) begin
        e_hs    = !(m_h >= HS_START && m_h < HS_START + H_SYNC);
        e_vs    = !(m_v >= V_VISIBLE + V_FP && m_v < V_VISIBLE + V_FP + V_SYNC);
        e_blank = m_vis;
        e_rgb   = '0;
        if (m_vis) begin
          if (m_h % 2 == 0) begin
            if (!fi.fifo_empty) begin
              m_word = q[0];
              m_ok   = 1'b1;
              e_rgb  = expand565(m_word[15:0]);
            end else begin
              m_ok = 1'b0;
              e_uf = 1'b1;
            end
          end else if (m_ok) begin
            e_rgb = expand565(m_word[31:16]);
          end
        end
      end
    end
    if (dut_pop && q.size() > 0) void'(q.pop_front());

    #1;
    if (q.size() < 8 && $urandom_range(0, 99) < push_rate) q.push_back($urandom);
    if (empty_rate > 0 && $urandom_range(0, 999) < empty_rate) forced_empty = !forced_empty;
    drive_inputs();
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 24'h0);
    check({tag, "_hs"}, vga_hs, 1'b1);
    check({tag, "_vs"}, vga_vs, 1'b1);
    check({tag, "_blank_n"}, vga_blank_n, 1'b0);
    check({tag, "_underflow"}, underflow, 1'b0);
    check({tag, "_rd_en"}, fi.fifo_rd_en, 1'b0);
    check({tag, "_frame_start"}, frame_start, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    int          p0;
    n_checks     = 0;
    n_pass       = 0;
    pops         = 0;
    frames       = 0;
    armed        = 1'b0;
    n_edges      = 0;
    forced_empty = 1'b0;
    push_rate    = 100;
    empty_rate   = 0;
    q            = {32'hF800_07E0, 32'h8410_8410, 32'h0000_001F};
    drive_inputs();

    // Reset held 5 clocks, then the first pixel tick lands CLK_DIV clocks after release
    reset = 1'b1;
    steps(5);
    reset = 1'b0;
    check_reset_values("rst");
    pops = 0;
    steps(CLK_DIV - 1);
    check("pre_tick_blank_n", vga_blank_n, 1'b0);
    check("pre_tick_pops", pops, 0);
    steps(1);
    check("px0_rgb", {vga_r, vga_g, vga_b}, 24'h00FF00);
    check("px0_model", e_rgb, 24'h00FF00);
    check("px0_blank_n", vga_blank_n, 1'b1);
    check("px0_pops", pops, 1);
    steps(CLK_DIV);
    check("px1_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);
    check("px1_pops", pops, 1);
    steps(CLK_DIV);
    check("px2_rgb", {vga_r, vga_g, vga_b}, 24'h848284);
    steps(CLK_DIV);
    check("px3_rgb", {vga_r, vga_g, vga_b}, 24'h848284);
    steps(CLK_DIV);
    check("px4_rgb", {vga_r, vga_g, vga_b}, 24'h0000FF);
    check("px4_model", e_rgb, 24'h0000FF);

    // Full frame with the FIFO never empty: sync placement, pop count, one frame_start
    reset = 1'b1;
    steps(2);
    reset  = 1'b0;
    pops   = 0;
    frames = 0;
    steps(HS_START * CLK_DIV);
    check("hs_before_start", vga_hs, 1'b1);
    steps(CLK_DIV);
    check("hs_at_start", vga_hs, 1'b0);
    steps((H_SYNC - 1) * CLK_DIV);
    check("hs_last", vga_hs, 1'b0);
    steps(CLK_DIV);
    check("hs_after_end", vga_hs, 1'b1);
    steps(FRAME_TICKS * CLK_DIV - (HS_START + H_SYNC + 1) * CLK_DIV);
    check("frame_pops", pops, (H_VISIBLE / 2) * V_VISIBLE);
    check("frame_starts", frames, 1);

    // FIFO empty for pixels 4,5: both black, no pop, sticky underflow, resume with next word
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(4 * CLK_DIV);
    forced_empty = 1'b1;
    drive_inputs();
    p0 = pops;
    steps(CLK_DIV);
    check("uf_even_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check("uf_even_blank_n", vga_blank_n, 1'b1);
    check("uf_set", underflow, 1'b1);
    steps(CLK_DIV);
    check("uf_odd_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check("uf_no_pop", pops, p0);
    w = q[0];
    forced_empty = 1'b0;
    drive_inputs();
    steps(CLK_DIV);
    check("resume_even_rgb", {vga_r, vga_g, vga_b}, expand565(w[15:0]));
    check("resume_pop", pops, p0 + 1);
    steps(CLK_DIV);
    check("resume_odd_rgb", {vga_r, vga_g, vga_b}, expand565(w[31:16]));
    steps(8 * CLK_DIV);
    check("uf_sticky", underflow, 1'b1);

    // Random FIFO fill and dry spells over several frames
    push_rate  = 60;
    empty_rate = 30;
    steps(3 * FRAME_TICKS * CLK_DIV);

    // Mid-frame reset: reset values next clock, then restart from (0,0)
    empty_rate   = 0;
    push_rate    = 100;
    forced_empty = 1'b0;
    reset        = 1'b1;
    steps(1);
    check_reset_values("midrst");
    steps(2);
    reset = 1'b0;
    pops  = 0;
    steps(CLK_DIV - 1);
    check("midrst_no_early_pop", pops, 0);
    steps(1);
    check("midrst_first_pop", pops, 1);
    check("midrst_uf_clear", underflow, 1'b0);

    push_rate  = 50;
    empty_rate = 20;
    steps(2 * FRAME_TICKS * CLK_DIV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
